spi_slave_regif: RTL and testbench

SPI_SLAVE_REGIF -- requirements
Module: spi_slave_regif

---
 rtl/spi_slave_regif.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave bridging a byte-oriented register interface.
// All SPI pins are oversampled in the clk domain. The first byte of a frame is
// {addr[6:0], rw}. Every following byte is either a register write or a read
// with prefetch.
module spi_slave_regif #(
    parameter bit AUTO_INC = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cs_sync_reg, sclk_sync_reg, mosi_sync_reg;
    logic        sclk_prev_reg;
    logic [1:0]  settle_reg;
    logic        armed_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  rx_shift_reg, tx_shift_reg;
    logic [6:0]  reg_addr_reg;
    logic [7:0]  reg_wdata_reg;
    logic        reg_we_reg, reg_re_reg, load_pending_reg, miso_reg;

    logic        cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall, byte_done;
    logic [7:0]  rx_byte;
    logic        start_frame, addr_latch, addr_step, we_set, re_set;
    logic        tx_load, tx_shift;

    assign cs_s      = cs_sync_reg[1];
    assign sclk_s    = sclk_sync_reg[1];
    assign mosi_s    = mosi_sync_reg[1];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign rx_byte   = {rx_shift_reg[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);

    // Prefetched data is loaded one clk after reg_re, only while the read is still live.
    assign tx_load  = load_pending_reg && (state_reg == RD_DATA) && !cs_s;
    // The fall right after a byte boundary keeps the freshly loaded MSB on the line.
    assign tx_shift = (state_reg == RD_DATA) && sclk_fall && (bit_cnt_reg != 3'd0);

    // Two-flop synchronizers, sclk edge history and post-reset arming on a seen-high cs_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_reg   <= 2'b11;
            sclk_sync_reg <= 2'b00;
            mosi_sync_reg <= 2'b00;
            sclk_prev_reg <= 1'b0;
            settle_reg    <= 2'b00;
            armed_reg     <= 1'b0;
        end else begin
            cs_sync_reg   <= {cs_sync_reg[0], cs_n};
            sclk_sync_reg <= {sclk_sync_reg[0], sclk};
            mosi_sync_reg <= {mosi_sync_reg[0], mosi};
            sclk_prev_reg <= sclk_s;
            settle_reg    <= {settle_reg[0], 1'b1};
            armed_reg     <= armed_reg | (settle_reg[1] & cs_s);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and strobe decisions; a high cs_s always wins over a completed byte.
    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        addr_latch  = 1'b0;
        addr_step   = 1'b0;
        we_set      = 1'b0;
        re_set      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (armed_reg && !cs_s) begin
                    state_next  = ADDR;
                    start_frame = 1'b1;
                end
            end
            ADDR: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    addr_latch = 1'b1;
                    if (rx_byte[0]) begin
                        state_next = RD_DATA;
                        re_set     = 1'b1;
                    end else begin
                        state_next = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (cs_s)           state_next = IDLE;
                else if (byte_done) we_set     = 1'b1;
            end
            RD_DATA: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    re_set    = 1'b1;
                    addr_step = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Receive shifter and bit counter; the counter wraps 7->0 for unlimited bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 8'h00;
        end else if (start_frame) begin
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 8'h00;
        end else if ((state_reg != IDLE) && sclk_rise) begin
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            rx_shift_reg <= rx_byte;
        end
    end

    // Register address, write data and the single-clk strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_addr_reg     <= 7'h00;
            reg_wdata_reg    <= 8'h00;
            reg_we_reg       <= 1'b0;
            reg_re_reg       <= 1'b0;
            load_pending_reg <= 1'b0;
        end else begin
            reg_we_reg       <= we_set;
            reg_re_reg       <= re_set;
            load_pending_reg <= reg_re_reg;
            if (we_set) reg_wdata_reg <= rx_byte;
            if (addr_latch) begin
                reg_addr_reg <= rx_byte[7:1];
            end else if ((addr_step || reg_we_reg) && AUTO_INC) begin
                reg_addr_reg <= reg_addr_reg + 7'd1;
            end
        end
    end

    // Transmit shifter and miso; miso is held low whenever the next state is not a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_reg <= 8'h00;
            miso_reg     <= 1'b0;
        end else begin
            if (start_frame)   tx_shift_reg <= 8'h00;
            else if (tx_load)  tx_shift_reg <= reg_rdata;
            else if (tx_shift) tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};

            if (state_next != RD_DATA) miso_reg <= 1'b0;
            else if (tx_load)          miso_reg <= reg_rdata[7];
            else if (tx_shift)         miso_reg <= tx_shift_reg[6];
        end
    end

    assign miso      = miso_reg;
    assign miso_oe   = ~cs_s;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign reg_we    = reg_we_reg;
    assign reg_re    = reg_re_reg;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: one auto-increment instance (a) and one fixed-address
// instance (b) share sclk/mosi with separate chip selects. A vector table drives frames.
// Strobe monitors pop expected strobes from scoreboard queues.
module tb_spi_slave_regif;

    localparam int HALF = 200;  // 20 clk per sclk phase

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cs_n_a, cs_n_b, sclk, mosi;
    logic       miso_a, miso_oe_a, reg_we_a, reg_re_a;
    logic       miso_b, miso_oe_b, reg_we_b, reg_re_b;
    logic [6:0] reg_addr_a, reg_addr_b;
    logic [7:0] reg_wdata_a, reg_wdata_b, reg_rdata_a, reg_rdata_b;

    spi_slave_regif #(.AUTO_INC(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n_a), .sclk(sclk), .mosi(mosi),
        .miso(miso_a), .miso_oe(miso_oe_a), .reg_addr(reg_addr_a), .reg_wdata(reg_wdata_a),
        .reg_we(reg_we_a), .reg_re(reg_re_a), .reg_rdata(reg_rdata_a)
    );

    spi_slave_regif #(.AUTO_INC(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n_b), .sclk(sclk), .mosi(mosi),
        .miso(miso_b), .miso_oe(miso_oe_b), .reg_addr(reg_addr_b), .reg_wdata(reg_wdata_b),
        .reg_we(reg_we_b), .reg_re(reg_re_b), .reg_rdata(reg_rdata_b)
    );

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } we_t;

    typedef struct packed {
        logic            inst_b;
        logic [2:0]      nbytes;
        logic [3:0]      cut;
        logic [3:0][7:0] tx;
        logic [1:0]      n_exp;
        logic [2:0][6:0] ea;
        logic [2:0][7:0] ed;
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         we_cnt_a = 0;
    we_t        we_q_a[$];
    we_t        we_q_b[$];
    logic [6:0] re_q_a[$];
    logic [7:0] rd_q[$];
    logic [7:0] mem [128];
    we_t        mon_e_a, mon_e_b;
    logic       we_a_prev = 1'b0, re_a_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_evt(input string name, input logic [6:0] addr);
        n_checks++;
        $display("FAIL %s: got strobe at addr 0x%0h, expected none", name, addr);
    endtask

    // Register-file model: data valid for exactly the clk after reg_re, garbage otherwise.
    always @(posedge clk) begin
        reg_rdata_a <= reg_re_a ? mem[reg_addr_a] : 8'($urandom);
        reg_rdata_b <= reg_re_b ? mem[reg_addr_b] : 8'($urandom);
    end

    // Strobe monitor for instance a.
    always @(negedge clk) begin
        if (reg_we_a) begin
            we_cnt_a <= we_cnt_a + 1;
            if (we_q_a.size() == 0) fail_evt("we_a_unexpected", reg_addr_a);
            else begin
                mon_e_a = we_q_a.pop_front();
                chk("we_a_addr", 32'(reg_addr_a), 32'(mon_e_a.a));
                chk("we_a_data", 32'(reg_wdata_a), 32'(mon_e_a.d));
            end
        end
        if (reg_re_a) begin
            if (re_q_a.size() == 0) fail_evt("re_a_unexpected", reg_addr_a);
            else chk("re_a_addr", 32'(reg_addr_a), 32'(re_q_a.pop_front()));
        end
        if (reg_we_a && reg_re_a) fail_evt("we_re_overlap_a", reg_addr_a);
        if (reg_we_a && we_a_prev) fail_evt("we_a_wide", reg_addr_a);
        if (reg_re_a && re_a_prev) fail_evt("re_a_wide", reg_addr_a);
        we_a_prev <= reg_we_a;
        re_a_prev <= reg_re_a;
    end

    // Strobe monitor for instance b (writes only).
    always @(negedge clk) begin
        if (reg_we_b) begin
            if (we_q_b.size() == 0) fail_evt("we_b_unexpected", reg_addr_b);
            else begin
                mon_e_b = we_q_b.pop_front();
                chk("we_b_addr", 32'(reg_addr_b), 32'(mon_e_b.a));
                chk("we_b_data", 32'(reg_wdata_b), 32'(mon_e_b.d));
            end
        end
        if (reg_re_b) fail_evt("re_b_unexpected", reg_addr_b);
    end

    function automatic vec_t mk(input logic ib, input int nb, input int cut,
                                input logic [7:0] t0, input logic [7:0] t1,
                                input logic [7:0] t2, input logic [7:0] t3, input int ne,
                                input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        vec_t v;
        v.inst_b = ib;
        v.nbytes = 3'(nb);
        v.cut    = 4'(cut);
        v.tx     = {t3, t2, t1, t0};
        v.n_exp  = 2'(ne);
        v.ea     = {a2, a1, a0};
        v.ed     = {d2, d1, d0};
        return v;
    endfunction

    task automatic set_cs(input logic ib, input logic v);
        if (ib) cs_n_b = v;
        else    cs_n_a = v;
    endtask

    function automatic logic miso_of(input logic ib);
        return ib ? miso_b : miso_a;
    endfunction

    task automatic spi_begin(input logic ib);
        @(negedge clk);
        set_cs(ib, 1'b0);
        #(HALF);
    endtask

    // Mode-0 master: mosi changes on the fall, miso sampled at the rise.
    task automatic spi_byte(input logic ib, input logic [7:0] tx, input int nbits,
                            input bit abort_last, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            #(HALF);
            if (abort_last && i == nbits - 1) set_cs(ib, 1'b1);
            sclk = 1'b1;
            rx[7-i] = miso_of(ib);
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end(input logic ib);
        #(HALF);
        set_cs(ib, 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic       is_rd;
        logic [7:0] rx, exp;
        int         nb;
        is_rd = v.tx[0][0];
        for (int k = 0; k < int'(v.n_exp); k++) begin
            if (is_rd)         re_q_a.push_back(v.ea[k]);
            else if (v.inst_b) we_q_b.push_back({v.ea[k], v.ed[k]});
            else               we_q_a.push_back({v.ea[k], v.ed[k]});
        end
        if (is_rd)
            for (int k = 0; k < int'(v.nbytes) - 1; k++) rd_q.push_back(v.ed[k]);
        spi_begin(v.inst_b);
        for (int b = 0; b < int'(v.nbytes); b++) begin
            nb = (b == int'(v.nbytes) - 1 && v.cut != 4'd0) ? int'(v.cut) : 8;
            spi_byte(v.inst_b, v.tx[b], nb, 1'b0, rx);
            if (is_rd && b > 0) begin
                exp = rd_q.pop_front();
                chk($sformatf("vec%0d_miso_byte%0d", idx, b), 32'(rx), 32'(exp));
            end
        end
        spi_end(v.inst_b);
        chk($sformatf("vec%0d_pending_strobes", idx),
            we_q_a.size() + we_q_b.size() + re_q_a.size(), 0);
        we_q_a.delete();
        we_q_b.delete();
        re_q_a.delete();
        rd_q.delete();
    endtask

    vec_t vecs [8];

    initial begin
        logic [7:0] rx, m;
        int         cnt0;

        vecs[0] = mk(0, 2, 0, 8'h2C, 8'hA5, 8'h00, 8'h00, 1, 7'h16, 7'h00, 7'h00, 8'hA5, 8'h00, 8'h00);
        vecs[1] = mk(0, 4, 0, 8'h2C, 8'h11, 8'h22, 8'h33, 3, 7'h16, 7'h17, 7'h18, 8'h11, 8'h22, 8'h33);
        vecs[2] = mk(1, 4, 0, 8'h2C, 8'h11, 8'h22, 8'h33, 3, 7'h16, 7'h16, 7'h16, 8'h11, 8'h22, 8'h33);
        vecs[3] = mk(0, 3, 0, 8'h01, 8'h00, 8'h00, 8'h00, 3, 7'h00, 7'h01, 7'h02, 8'hAD, 8'h1D, 8'h00);
        vecs[4] = mk(0, 3, 0, 8'hFE, 8'h01, 8'h02, 8'h00, 2, 7'h7F, 7'h00, 7'h00, 8'h01, 8'h02, 8'h00);
        vecs[5] = mk(0, 2, 5, 8'h2C, 8'h77, 8'h00, 8'h00, 0, 7'h00, 7'h00, 7'h00, 8'h00, 8'h00, 8'h00);
        vecs[6] = mk(0, 2, 0, 8'h80, 8'h3C, 8'h00, 8'h00, 1, 7'h40, 7'h00, 7'h00, 8'h3C, 8'h00, 8'h00);
        vecs[7] = mk(0, 2, 0, 8'h21, 8'h00, 8'h00, 8'h00, 2, 7'h10, 7'h11, 7'h00, 8'hC3, 8'h00, 8'h00);

        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 7 + 3);
        mem[0]    = 8'hAD;
        mem[1]    = 8'h1D;
        mem[2]    = 8'h42;
        mem[7'h10] = 8'hC3;
        mem[7'h11] = 8'h99;

        rst_n  = 1'b0;
        cs_n_a = 1'b1;
        cs_n_b = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso_a), 0);
        chk("rst_miso_oe", 32'(miso_oe_a), 0);
        chk("rst_reg_we", 32'(reg_we_a), 0);
        chk("rst_reg_re", 32'(reg_re_a), 0);
        chk("rst_reg_addr", 32'(reg_addr_a), 0);
        chk("rst_reg_wdata", 32'(reg_wdata_a), 0);
        chk("rst_miso_oe_b", 32'(miso_oe_b), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // cs_n rises together with the 8th rise of a data byte: abort wins.
        cnt0 = we_cnt_a;
        spi_begin(1'b0);
        spi_byte(1'b0, 8'h2C, 8, 1'b0, rx);
        spi_byte(1'b0, 8'h55, 8, 1'b1, rx);
        spi_end(1'b0);
        chk("coincident_abort_we", we_cnt_a - cnt0, 0);
        run_vec(vecs[0], 100);

        // Reset pulsed mid-read, then cs_n held low across release.
        re_q_a.push_back(7'h00);
        spi_begin(1'b0);
        spi_byte(1'b0, 8'h01, 8, 1'b0, rx);
        spi_byte(1'b0, 8'h00, 2, 1'b0, rx);
        repeat (10) @(negedge clk);
        m = mem[0];
        chk("pre_reset_miso", 32'(miso_a), 32'(m[5]));
        chk("pre_reset_miso_oe", 32'(miso_oe_a), 1);
        rst_n = 1'b0;
        #1;
        chk("reset_miso", 32'(miso_a), 0);
        chk("reset_miso_oe", 32'(miso_oe_a), 0);
        chk("reset_pending_re", re_q_a.size(), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        cnt0 = we_cnt_a;
        spi_byte(1'b0, 8'h2C, 8, 1'b0, rx);
        spi_byte(1'b0, 8'hA5, 8, 1'b0, rx);
        spi_end(1'b0);
        chk("no_decode_without_fresh_cs", we_cnt_a - cnt0, 0);
        run_vec(vecs[0], 200);
        run_vec(vecs[3], 201);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
